muldiv_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 34 +++
 rtl/sign_cond.sv | 15 +
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MD_* : 3-bit operation codes presented on muldiv_unit.op
//   - md_state_e : controller states of the iterative engine
//   - md_is_arith / md_is_signed / md_is_div : op-code classification helpers
package mips_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // MULT/MULTU/DIV/DIVU all have op[2] clear.
    function automatic logic md_is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

    // Within the arithmetic class the unsigned variants have op[0] set.
    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/sign_cond.sv
// Conditional two's-complement negate.
//   neg : 1 -> y = -x, 0 -> y = x
//   x   : operand
//   y   : result
module sign_cond #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, on operand magnitudes;
// signs are reapplied in a final FIX cycle.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   start  : launch request, honoured only while busy = 0
//   op     : MULT/MULTU/DIV/DIVU/MTHI/MTLO (110/111 no-op)
//   a, b   : operands, captured on the accepting edge
//   flush  : synchronous abort; returns to IDLE without touching HI/LO
//   busy   : multiply/divide in flight
//   done   : one-cycle pulse when new HI/LO values appear
//   hi, lo : architectural HI/LO registers
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;    // multiplicand / dividend (shifts left in divide)
    logic [WIDTH-1:0]   op_b_q, op_b_d;    // multiplier (shifts right) / divisor
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               is_div_q, is_div_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_new;

    assign neg_a = md_is_signed(op) & a[WIDTH-1];
    assign neg_b = md_is_signed(op) & b[WIDTH-1];

    sign_cond #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .x(a), .y(abs_a));
    sign_cond #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .x(b), .y(abs_b));

    sign_cond #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg (sa_q ^ sb_q),
        .x   (acc_q),
        .y   (prod_fix)
    );
    sign_cond #(.WIDTH(WIDTH)) u_fix_quo (
        .neg (sa_q ^ sb_q),
        .x   (acc_q[WIDTH-1:0]),
        .y   (quo_fix)
    );
    sign_cond #(.WIDTH(WIDTH)) u_fix_rem (
        .neg (sa_q),
        .x   (acc_q[2*WIDTH-1:WIDTH]),
        .y   (rem_fix)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        // Multiply step: add multiplicand into the upper half, shift whole accumulator right.
        mul_add = op_b_q[0] ? op_a_q : '0;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

        // Divide step: upper half is the partial remainder, lower half collects quotient bits.
        // The shifted remainder is < 2*divisor, so bit WIDTH of the trial is a valid sign.
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], op_a_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, op_b_q};
        rem_new = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (md_is_arith(op)) begin
                        state_d  = RUN;
                        cnt_d    = CW'(WIDTH - 1);
                        acc_d    = '0;
                        op_a_d   = abs_a;
                        op_b_d   = abs_b;
                        sa_d     = neg_a;
                        sb_d     = neg_b;
                        is_div_d = md_is_div(op);
                        bzero_d  = (b == '0);
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d  = {rem_new, acc_q[WIDTH-2:0], ~trial[WIDTH]};
                    op_a_d = op_a_q << 1;
                end else begin
                    acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
                    op_b_d = op_b_q >> 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Divide by zero: the remainder path already yields the original a.
                    hi_d = rem_fix;
                    lo_d = bzero_q ? '1 : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural HI/LO as the model believes them to be.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_md(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        longint       sx, sy;
        logic [W-1:0] q, r;
        logic [2*W-1:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            OP_MULT:  res = 64'(sx * sy);
            OP_MULTU: res = {32'b0, x} * {32'b0, y};
            OP_DIV, OP_DIVU: begin
                if (y == '0) begin
                    res = {x, {W{1'b1}}};
                end else begin
                    if (o == OP_DIV) begin
                        q = W'(sx / sy);
                        r = W'(sx % sy);
                    end else begin
                        q = x / y;
                        r = x % y;
                    end
                    res = {r, q};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Present a request for one edge; returns #1 after the accepting edge.
    // Operands are scrambled afterwards so late sampling would show up.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'b111;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts edges after the accept edge until done, and cycles with busy seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 3 * W) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1 && done !== 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++;
        if (hi !== '0) $display("FAIL reset_hi: got %h expected 0", hi); else n_pass++;
        n_checks++;
        if (lo !== '0) $display("FAIL reset_lo: got %h expected 0", lo); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
    endtask

    task automatic test_mult_signed();
        int lat, bcnt;
        @(negedge clk);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bcnt);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi);
        else n_pass++;
        n_checks++;
        if (lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h expected ffffffeb", lo);
        else n_pass++;
        n_checks++;
        if (lat != W + 1) $display("FAIL mult_latency: got %0d expected %0d", lat, W + 1);
        else n_pass++;
        n_checks++;
        if (bcnt != W + 1) $display("FAIL mult_busy_cycles: got %0d expected %0d", bcnt, W + 1);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL mult_done_width: got %b expected 0", done);
        else n_pass++;
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;
    endtask

    task automatic test_multu_mthi();
        int lat, bcnt;
        @(negedge clk);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
        else n_pass++;
        @(negedge clk);
        launch(OP_MTHI, 32'h0000_1234, 32'h0);
        n_checks++;
        if (hi !== 32'h0000_1234) $display("FAIL mthi_hi: got %h expected 00001234", hi);
        else n_pass++;
        n_checks++;
        if (lo !== 32'h0000_0001) $display("FAIL mthi_lo_kept: got %h expected 00000001", lo);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mthi_busy_done: got busy=%b done=%b expected 0/0", busy, done);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mthi_after: got busy=%b done=%b expected 0/0", busy, done);
        else n_pass++;
        m_hi = 32'h0000_1234;
        m_lo = 32'h0000_0001;
    endtask

    task automatic test_div();
        int lat, bcnt;
        @(negedge clk);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
            $display("FAIL div_neg: got %h_%h expected ffffffff_fffffffd", hi, lo);
        else n_pass++;
        n_checks++;
        if (lat != W + 1) $display("FAIL div_latency: got %0d expected %0d", lat, W + 1);
        else n_pass++;
        @(negedge clk);
        launch(OP_DIVU, 32'd7, 32'd0);
        wait_done(lat, bcnt);
        n_checks++;
        if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF)
            $display("FAIL divu_by_zero: got %h_%h expected 00000007_ffffffff", hi, lo);
        else n_pass++;
        @(negedge clk);
        launch(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        wait_done(lat, bcnt);
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFF0_FFFF_FFFF)
            $display("FAIL div_by_zero: got %h_%h expected fffffff0_ffffffff", hi, lo);
        else n_pass++;
        m_hi = 32'hFFFF_FFF0;
        m_lo = 32'hFFFF_FFFF;
    endtask

    task automatic test_div_ovf_b2b();
        int lat, bcnt;
        logic [2*W-1:0] exp;
        @(negedge clk);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        n_checks++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000)
            $display("FAIL div_min_neg1: got %h_%h expected 00000000_80000000", hi, lo);
        else n_pass++;
        // Still inside the done cycle: issue the next divide immediately.
        launch(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
        else n_pass++;
        wait_done(lat, bcnt);
        exp = ref_md(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        n_checks++;
        if ({hi, lo} !== exp) $display("FAIL b2b_result: got %h_%h expected %h", hi, lo, exp);
        else n_pass++;
        n_checks++;
        if (lat != W + 1) $display("FAIL b2b_latency: got %0d expected %0d", lat, W + 1);
        else n_pass++;
        {m_hi, m_lo} = exp;
    endtask

    task automatic test_ignore_start();
        int lat, bcnt;
        logic [W-1:0] x, y;
        logic [2*W-1:0] exp;
        x = $urandom;
        y = $urandom;
        @(negedge clk);
        launch(OP_MULT, x, y);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_DIVU;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        exp = ref_md(OP_MULT, x, y);
        n_checks++;
        if ({hi, lo} !== exp) $display("FAIL ignore_start_result: got %h_%h expected %h", hi, lo, exp);
        else n_pass++;
        n_checks++;
        if (lat + 5 != W + 1)
            $display("FAIL ignore_start_latency: got %0d expected %0d", lat + 5, W + 1);
        else n_pass++;
        {m_hi, m_lo} = exp;
    endtask

    task automatic test_flush();
        int ndone;
        @(negedge clk);
        launch(OP_MULTU, $urandom, $urandom);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
        ndone = 0;
        repeat (W + 8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) $display("FAIL flush_no_done: got %0d done pulses expected 0", ndone);
        else n_pass++;
        n_checks++;
        if (hi !== m_hi || lo !== m_lo)
            $display("FAIL flush_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo);
        else n_pass++;
        // Flush beats a same-edge MTLO and a same-edge MULT.
        @(negedge clk);
        flush = 1'b1;
        launch(OP_MTLO, ~m_lo, 32'h0);
        n_checks++;
        if (lo !== m_lo) $display("FAIL flush_mtlo: got %h expected %h", lo, m_lo); else n_pass++;
        launch(OP_MULT, 32'd3, 32'd5);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_start: got busy=%b expected 0", busy); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat, bcnt;
        @(negedge clk);
        launch(OP_MTHI, 32'hDEAD_0001, 32'h0);
        launch(OP_MTLO, 32'hBEEF_0002, 32'h0);
        launch(OP_DIVU, $urandom, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL async_reset_ctl: got busy=%b done=%b expected 0/0", busy, done);
        else n_pass++;
        n_checks++;
        if (hi !== '0 || lo !== '0)
            $display("FAIL async_reset_hilo: got %h_%h expected 0_0", hi, lo);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        launch(OP_MULT, 32'd6, 32'd7);
        wait_done(lat, bcnt);
        n_checks++;
        if (lo !== 32'd42 || hi !== '0)
            $display("FAIL post_reset_mult: got %h_%h expected 00000000_0000002a", hi, lo);
        else n_pass++;
        n_checks++;
        if (lat != W + 1) $display("FAIL post_reset_latency: got %0d expected %0d", lat, W + 1);
        else n_pass++;
        m_hi = '0;
        m_lo = 32'd42;
    endtask

    task automatic test_random();
        int lat, bcnt, sel;
        logic [2:0] o;
        logic [W-1:0] x, y;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(7);
            if (sel == 0) y = '0;
            else if (sel == 1) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end else if (sel == 2) y = 32'($urandom_range(15));
            @(negedge clk);
            launch(o, x, y);
            if (o <= OP_DIVU) begin
                wait_done(lat, bcnt);
                exp = ref_md(o, x, y);
                n_checks++;
                if ({hi, lo} !== exp || lat != W + 1)
                    $display("FAIL random_op%0d: op=%0d a=%h b=%h got %h_%h lat %0d expected %h lat %0d",
                             i, o, x, y, hi, lo, lat, exp, W + 1);
                else n_pass++;
                {m_hi, m_lo} = exp;
            end else begin
                if (o == OP_MTHI) m_hi = x;
                if (o == OP_MTLO) m_lo = x;
                n_checks++;
                if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0)
                    $display("FAIL random_move%0d: op=%0d got %h_%h busy %b done %b expected %h_%h 0 0",
                             i, o, hi, lo, busy, done, m_hi, m_lo);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_mthi();
        test_div();
        test_div_ovf_b2b();
        test_ignore_start();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
